// File: rtl/ysyx_22040750_intr_arbiter.sv
// ysyx_22040750_intr_arbiter
// M-mode interrupt arbiter: registers MSIP/MTIP/MEIP and masks them with mie/mstatus.MIE.
// It also masks them with CSR writes and traps still in flight in the younger pipeline stages.
// It raises one prioritised request (MEI > MSI > MTI) to ID over a req/ack handshake.
// After each accepted request it holds off for HOLDOFF cycles.
module ysyx_22040750_intr_arbiter #(
    parameter int NSTAGE  = 3,
    parameter int XLEN    = 64,
    parameter int HOLDOFF = 4,
    parameter int CNT_W   = 32
) (
    input  logic                     I_sys_clk,
    input  logic                     I_rst,
    input  logic                     I_irq_msip,
    input  logic                     I_irq_mtip,
    input  logic                     I_irq_meip,
    input  logic                     I_csr_mstatus_mie,
    input  logic [XLEN-1:0]          I_csr_mie,
    input  logic [NSTAGE-1:0]        I_stage_trap,
    input  logic [NSTAGE-1:0]        I_stage_csr_wen,
    input  logic [12*NSTAGE-1:0]     I_stage_csr_addr,
    input  logic [XLEN*NSTAGE-1:0]   I_stage_csr_data,
    input  logic                     I_intr_ack,
    output logic                     O_intr_req,
    output logic [XLEN-1:0]          O_intr_cause,
    output logic [XLEN-1:0]          O_mip,
    output logic [CNT_W-1:0]         O_intr_cnt
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Source vectors are ordered {MEI, MTI, MSI}, i.e. mip bits {11, 7, 3}.
    state_e              state_q, state_d;
    logic [2:0]          pend_q;
    logic [2:0]          sel_q, sel_d;
    logic [XLEN-1:0]     cause_q, cause_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                kill_all_s;
    logic [2:0]          kill_src_s;
    logic [2:0]          mie_s;
    logic [2:0]          elig_s;
    logic                req_s;
    logic                unused_s;

    // Build an mcause value: interrupt flag in the MSB, exception code in the low bits.
    function automatic logic [XLEN-1:0] cause_of(input logic [3:0] code);
        logic [XLEN-1:0] c;
        c          = '0;
        c[XLEN-1]  = 1'b1;
        c[3:0]     = code;
        return c;
    endfunction

    // Only mie bits 3/7/11 and data bits 3/7/11 matter; the rest are intentionally ignored.
    assign unused_s = ^{I_csr_mie, I_stage_csr_data};

    assign mie_s = {I_csr_mie[11], I_csr_mie[7], I_csr_mie[3]};

    // Decode in-flight CSR writes and traps that must suppress interrupts.
    // A trap or an mstatus write that clears MIE suppresses every source.
    // An mie write suppresses each source whose enable bit it clears.
    always_comb begin
        kill_all_s = 1'b0;
        kill_src_s = 3'b000;
        for (int i = 0; i < NSTAGE; i++) begin
            kill_all_s = kill_all_s | I_stage_trap[i]
                       | (I_stage_csr_wen[i]
                          & (I_stage_csr_addr[12*i +: 12] == CSR_MSTATUS)
                          & ~I_stage_csr_data[XLEN*i + 3]);
            kill_src_s[0] = kill_src_s[0]
                          | (I_stage_csr_wen[i] & (I_stage_csr_addr[12*i +: 12] == CSR_MIE)
                             & ~I_stage_csr_data[XLEN*i + 3]);
            kill_src_s[1] = kill_src_s[1]
                          | (I_stage_csr_wen[i] & (I_stage_csr_addr[12*i +: 12] == CSR_MIE)
                             & ~I_stage_csr_data[XLEN*i + 7]);
            kill_src_s[2] = kill_src_s[2]
                          | (I_stage_csr_wen[i] & (I_stage_csr_addr[12*i +: 12] == CSR_MIE)
                             & ~I_stage_csr_data[XLEN*i + 11]);
        end
    end

    assign elig_s = pend_q & mie_s & {3{I_csr_mstatus_mie}} & ~kill_src_s & {3{~kill_all_s}};

    // Next-state and request logic for the IDLE / REQ / DRAIN handshake.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        req_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig_s[2]) begin
                    state_d = ST_REQ;
                    sel_d   = 3'b100;
                    cause_d = cause_of(4'd11);
                end else if (elig_s[0]) begin
                    state_d = ST_REQ;
                    sel_d   = 3'b001;
                    cause_d = cause_of(4'd3);
                end else if (elig_s[1]) begin
                    state_d = ST_REQ;
                    sel_d   = 3'b010;
                    cause_d = cause_of(4'd7);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The cause is frozen; a killed request drops low and resumes later.
                req_s = ~kill_all_s & ~(|(kill_src_s & sel_q));
                if (I_intr_ack && req_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = cnt_q + CNT_W'(1);
                    hold_d  = HOLD_W'(HOLDOFF - 1);
                end else if (!(|(pend_q & sel_q)) || !(|(mie_s & sel_q)) || !I_csr_mstatus_mie) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pending sample, frozen cause, hold-off and accept counter registers.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            pend_q  <= 3'b000;
            sel_q   <= 3'b000;
            cause_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= {I_irq_meip, I_irq_mtip, I_irq_msip};
            sel_q   <= sel_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Expose the registered pending bits at their architectural mip positions.
    always_comb begin
        O_mip     = '0;
        O_mip[3]  = pend_q[0];
        O_mip[7]  = pend_q[1];
        O_mip[11] = pend_q[2];
    end

    assign O_intr_req   = req_s;
    assign O_intr_cause = (state_q == ST_REQ) ? cause_q : '0;
    assign O_intr_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_22040750_intr_arbiter.sv
// Directed bench for ysyx_22040750_intr_arbiter.
// Expected outputs go into a scoreboard queue as stimulus is applied.
// They are popped and compared against two instances: default counter width and a 2-bit counter.
module tb_ysyx_22040750_intr_arbiter;

    localparam int NS = 3;
    localparam int XL = 64;

    localparam logic [63:0] C3  = 64'h8000_0000_0000_0003;
    localparam logic [63:0] C7  = 64'h8000_0000_0000_0007;
    localparam logic [63:0] C11 = 64'h8000_0000_0000_000B;

    logic              clk;
    logic              rst;
    logic              msip, mtip, meip, mstat;
    logic [XL-1:0]     mie;
    logic [NS-1:0]     st_trap, st_wen;
    logic [12*NS-1:0]  st_addr;
    logic [XL*NS-1:0]  st_data;
    logic              ack;
    logic              req, req_w;
    logic [XL-1:0]     cause, cause_w, mip, mip_w;
    logic [31:0]       cnt;
    logic [1:0]        cnt_w;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        req;
        logic [63:0] cause;
        logic [63:0] mip;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    ysyx_22040750_intr_arbiter #(.NSTAGE(NS), .XLEN(XL), .HOLDOFF(4), .CNT_W(32)) dut (
        .I_sys_clk(clk), .I_rst(rst),
        .I_irq_msip(msip), .I_irq_mtip(mtip), .I_irq_meip(meip),
        .I_csr_mstatus_mie(mstat), .I_csr_mie(mie),
        .I_stage_trap(st_trap), .I_stage_csr_wen(st_wen),
        .I_stage_csr_addr(st_addr), .I_stage_csr_data(st_data),
        .I_intr_ack(ack),
        .O_intr_req(req), .O_intr_cause(cause), .O_mip(mip), .O_intr_cnt(cnt)
    );

    ysyx_22040750_intr_arbiter #(.NSTAGE(NS), .XLEN(XL), .HOLDOFF(4), .CNT_W(2)) dut_w (
        .I_sys_clk(clk), .I_rst(rst),
        .I_irq_msip(msip), .I_irq_mtip(mtip), .I_irq_meip(meip),
        .I_csr_mstatus_mie(mstat), .I_csr_mie(mie),
        .I_stage_trap(st_trap), .I_stage_csr_wen(st_wen),
        .I_stage_csr_addr(st_addr), .I_stage_csr_data(st_data),
        .I_intr_ack(ack),
        .O_intr_req(req_w), .O_intr_cause(cause_w), .O_mip(mip_w), .O_intr_cnt(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string t, input logic r, input logic [63:0] c,
                              input logic [63:0] m, input logic [31:0] n);
        exp_t e;
        e.req   = r;
        e.cause = c;
        e.mip   = m;
        e.cnt   = n;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic cmp(input string t, input string f, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", t, f, obs, want);
        end
    endtask

    task automatic chk();
        exp_t  e;
        string t;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "req",   {63'd0, req},   {63'd0, e.req});
        cmp(t, "cause", cause,          e.cause);
        cmp(t, "mip",   mip,            e.mip);
        cmp(t, "cnt",   {32'd0, cnt},   {32'd0, e.cnt});
        cmp(t, "req_w", {63'd0, req_w}, {63'd0, e.req});
        cmp(t, "cnt_w", {62'd0, cnt_w}, {62'd0, e.cnt[1:0]});
    endtask

    task automatic set_stage(input int i, input logic trap, input logic wen,
                             input logic [11:0] a, input logic [63:0] d);
        st_trap[i]          = trap;
        st_wen[i]           = wen;
        st_addr[12*i +: 12] = a;
        st_data[XL*i +: XL] = d;
    endtask

    task automatic clear_stages();
        st_trap = '0;
        st_wen  = '0;
        st_addr = '0;
        st_data = '0;
    endtask

    initial begin
        rst = 1'b1; msip = 1'b0; mtip = 1'b0; meip = 1'b0; mstat = 1'b0;
        mie = 64'd0; ack = 1'b0;
        clear_stages();
        step(2);
        expect_out("reset", 1'b0, 64'd0, 64'd0, 32'd0); chk();
        rst = 1'b0;

        // T1: timer only; request two cycles after the level rises.
        mtip = 1'b1; mie = 64'h80; mstat = 1'b1;
        expect_out("t1_n0", 1'b0, 64'd0, 64'd0, 32'd0); chk();
        step(1);
        expect_out("t1_pend", 1'b0, 64'd0, 64'h80, 32'd0); chk();
        step(1);
        expect_out("t1_req", 1'b1, C7, 64'h80, 32'd0); chk();
        step(1);
        expect_out("t1_hold", 1'b1, C7, 64'h80, 32'd0); chk();
        ack = 1'b1;
        step(1);
        ack = 1'b0; mtip = 1'b0;
        expect_out("t1_drain", 1'b0, 64'd0, 64'h80, 32'd1); chk();
        step(5);
        expect_out("t1_idle", 1'b0, 64'd0, 64'd0, 32'd1); chk();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        expect_out("ack_idle", 1'b0, 64'd0, 64'd0, 32'd1); chk();

        // T2: MEI and MTI together; MEI wins, MTI follows after exactly four drain cycles.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_out("t2_rst", 1'b0, 64'd0, 64'd0, 32'd0); chk();
        mie = 64'h880; meip = 1'b1; mtip = 1'b1;
        step(2);
        expect_out("t2_req11", 1'b1, C11, 64'h880, 32'd0); chk();
        ack = 1'b1;
        step(1);
        ack = 1'b0; meip = 1'b0;
        expect_out("t2_drain0", 1'b0, 64'd0, 64'h880, 32'd1); chk();
        for (int k = 0; k < 3; k++) begin
            step(1);
            expect_out("t2_drain", 1'b0, 64'd0, 64'h80, 32'd1); chk();
        end
        step(1);
        expect_out("t2_idle", 1'b0, 64'd0, 64'h80, 32'd1); chk();
        step(1);
        expect_out("t2_req7", 1'b1, C7, 64'h80, 32'd1); chk();

        // T3: MEM stage clears mstatus.MIE -> request gated, ack ignored, then resumes.
        set_stage(1, 1'b0, 1'b1, 12'h300, 64'd0);
        ack = 1'b1;
        expect_out("t3_kill", 1'b0, C7, 64'h80, 32'd1); chk();
        step(1);
        expect_out("t3_ackign", 1'b0, C7, 64'h80, 32'd1); chk();
        clear_stages(); ack = 1'b0;
        expect_out("t3_resume", 1'b1, C7, 64'h80, 32'd1); chk();
        set_stage(1, 1'b0, 1'b1, 12'h300, 64'h8);
        expect_out("t3_mie_kept", 1'b1, C7, 64'h80, 32'd1); chk();
        clear_stages();
        set_stage(2, 1'b1, 1'b0, 12'h000, 64'd0);
        expect_out("t3_trap_wb", 1'b0, C7, 64'h80, 32'd1); chk();
        clear_stages();

        // T4: EX stage writes mie=0x8 -> only MTI killed; MSI arrival does not replace the cause.
        mie = 64'h888; msip = 1'b1;
        set_stage(0, 1'b0, 1'b1, 12'h304, 64'h8);
        expect_out("t4_kill7", 1'b0, C7, 64'h80, 32'd1); chk();
        step(1);
        expect_out("t4_msip", 1'b0, C7, 64'h88, 32'd1); chk();
        step(1);
        expect_out("t4_stay", 1'b0, C7, 64'h88, 32'd1); chk();
        set_stage(0, 1'b0, 1'b1, 12'h304, 64'h80);
        expect_out("t4_other_kill", 1'b1, C7, 64'h88, 32'd1); chk();
        clear_stages();
        expect_out("t4_resume", 1'b1, C7, 64'h88, 32'd1); chk();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        expect_out("t4_cnt2", 1'b0, 64'd0, 64'h88, 32'd2); chk();
        step(5);
        expect_out("t4_msi", 1'b1, C3, 64'h88, 32'd2); chk();

        // T5: MSI withdrawn before ack.
        msip = 1'b0; mtip = 1'b0;
        step(1);
        expect_out("t5_pdrop", 1'b1, C3, 64'd0, 32'd2); chk();
        step(1);
        expect_out("t5_wdraw", 1'b0, 64'd0, 64'd0, 32'd2); chk();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        expect_out("t5_nocnt", 1'b0, 64'd0, 64'd0, 32'd2); chk();

        // Global enable masking.
        mstat = 1'b0; meip = 1'b1; mie = 64'h800;
        step(3);
        expect_out("mstat_off", 1'b0, 64'd0, 64'h800, 32'd2); chk();
        mstat = 1'b1;
        step(1);
        expect_out("mstat_on", 1'b1, C11, 64'h800, 32'd2); chk();

        // T6: two more accepts wrap the 2-bit counter; reset during drain.
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        expect_out("t6_cnt3", 1'b0, 64'd0, 64'h800, 32'd3); chk();
        step(5);
        expect_out("t6_req", 1'b1, C11, 64'h800, 32'd3); chk();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        expect_out("t6_wrap", 1'b0, 64'd0, 64'h800, 32'd4); chk();
        step(1);
        rst = 1'b1;
        expect_out("t6_rst_async", 1'b0, 64'd0, 64'd0, 32'd0); chk();
        step(1);
        expect_out("t6_rst_hold", 1'b0, 64'd0, 64'd0, 32'd0); chk();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
